// File: rtl/prim_diff_encode_if.sv
// Request/fault-injection inputs and differential pair plus status outputs of prim_diff_encode.
// The master side drives requests and observes the pair; the slave side is the encoder.
interface prim_diff_encode_if;
    logic req_i;
    logic sigint_test_i;
    logic diff_po;
    logic diff_no;
    logic ack_o;
    logic busy_o;
    logic ovf_o;

    modport master (
        output req_i,
        output sigint_test_i,
        input  diff_po,
        input  diff_no,
        input  ack_o,
        input  busy_o,
        input  ovf_o
    );

    modport slave (
        input  req_i,
        input  sigint_test_i,
        output diff_po,
        output diff_no,
        output ack_o,
        output busy_o,
        output ovf_o
    );
endinterface

// File: rtl/prim_diff_encode.sv
// Differential level-toggle encoder: each request flips the pair, and each level is held HoldCycles cycles.
// Requests are queued in a saturating counter, and a test pulse in Idle forces equal wires for TestCycles cycles.
module prim_diff_encode #(
    parameter int unsigned HoldCycles = 4,
    parameter int unsigned TestCycles = 3,
    parameter int unsigned PendW      = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    prim_diff_encode_if.slave   bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_TEST = 2'd2;

    localparam logic [7:0]       HoldLd    = 8'(HoldCycles - 2);
    localparam logic [7:0]       TestLd    = 8'(TestCycles - 1);
    localparam bit               HoldMulti = (HoldCycles > 1);
    localparam logic [PendW-1:0] PendMax   = '1;
    localparam logic [PendW-1:0] PendOne   = PendW'(1);

    logic [1:0]       state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [PendW-1:0] pend_q, pend_d;
    logic             level_q, level_d;
    logic             diff_p_q, diff_p_d;
    logic             diff_n_q, diff_n_d;
    logic             ack_q, ack_d;
    logic             ovf_q, ovf_d;
    logic             take;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        ack_d   = 1'b0;
        take    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Fault injection wins over queued work; queued requests wait it out.
                if (bus.sigint_test_i) begin
                    state_d = ST_TEST;
                    cnt_d   = TestLd;
                end else if ((pend_q != '0) || bus.req_i) begin
                    take    = 1'b1;
                    level_d = ~level_q;
                    ack_d   = 1'b1;
                    if (HoldMulti) begin
                        state_d = ST_HOLD;
                        cnt_d   = HoldLd;
                    end
                end
            end
            ST_HOLD, ST_TEST: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // A request taken in the same cycle it arrives never touches the counter.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = 1'b0;
        if (bus.req_i && !take) begin
            if (pend_q == PendMax) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + PendOne;
            end
        end else if (!bus.req_i && take) begin
            pend_d = pend_q - PendOne;
        end
    end

    // Both wires come from flops fed by the same next-state, so their edges align.
    assign diff_p_d = level_d;
    assign diff_n_d = (state_d == ST_TEST) ? level_d : ~level_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 8'd0;
            pend_q   <= '0;
            level_q  <= 1'b0;
            diff_p_q <= 1'b0;
            diff_n_q <= 1'b1;
            ack_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            level_q  <= level_d;
            diff_p_q <= diff_p_d;
            diff_n_q <= diff_n_d;
            ack_q    <= ack_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.diff_po = diff_p_q;
    assign bus.diff_no = diff_n_q;
    assign bus.ack_o   = ack_q;
    assign bus.ovf_o   = ovf_q;
    assign bus.busy_o  = (state_q != ST_IDLE) || (pend_q != '0);

endmodule

// File: tb/tb_prim_diff_encode.sv
// Directed bench for prim_diff_encode: default instance A plus a HoldCycles=1 instance B.
// Cycle k is the interval after the k-th rising edge following reset release.
module tb_prim_diff_encode;
    logic clk_i = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    int   vec   = 0;
    int   errs  = 0;
    int   cyc   = 0;
    int   acks_a = 0, ovfs_a = 0, acks_b = 0, ovfs_b = 0;

    prim_diff_encode_if ifa ();
    prim_diff_encode_if ifb ();

    prim_diff_encode #(.HoldCycles(4), .TestCycles(3), .PendW(2)) u_dut_a (
        .clk_i  (clk_i),
        .rst_ni (rst_a),
        .bus    (ifa)
    );

    prim_diff_encode #(.HoldCycles(1), .TestCycles(3), .PendW(2)) u_dut_b (
        .clk_i  (clk_i),
        .rst_ni (rst_b),
        .bus    (ifb)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (rst_a && ifa.ack_o === 1'b1) acks_a++;
        if (rst_a && ifa.ovf_o === 1'b1) ovfs_a++;
        if (rst_b && ifb.ack_o === 1'b1) acks_b++;
        if (rst_b && ifb.ovf_o === 1'b1) ovfs_b++;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic reset_a();
        ifa.req_i = 1'b0;
        ifa.sigint_test_i = 1'b0;
        rst_a = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_a = 1'b1;
        cyc = 0;
        acks_a = 0;
        ovfs_a = 0;
    endtask

    task automatic test_reset();
        ifa.req_i = 1'b0;
        ifa.sigint_test_i = 1'b0;
        rst_a = 1'b0;
        @(posedge clk_i);
        #1;
        vec++; if (ifa.diff_po !== 1'b0) begin errs++; $display("FAIL reset_p got %b want 0", ifa.diff_po); end
        vec++; if (ifa.diff_no !== 1'b1) begin errs++; $display("FAIL reset_n got %b want 1", ifa.diff_no); end
        vec++; if (ifa.ack_o !== 1'b0) begin errs++; $display("FAIL reset_ack got %b want 0", ifa.ack_o); end
        vec++; if (ifa.busy_o !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", ifa.busy_o); end
        vec++; if (ifa.ovf_o !== 1'b0) begin errs++; $display("FAIL reset_ovf got %b want 0", ifa.ovf_o); end
    endtask

    task automatic test_single();
        reset_a();
        repeat (5) tick();
        ifa.req_i = 1'b1;
        tick();
        ifa.req_i = 1'b0;
        vec++; if (ifa.ack_o !== 1'b1) begin errs++; $display("FAIL single_ack c6 got %b want 1", ifa.ack_o); end
        for (int c = 6; c <= 9; c++) begin
            vec++;
            if (ifa.diff_po !== 1'b1 || ifa.diff_no !== 1'b0) begin
                errs++; $display("FAIL single_pair c%0d got p=%b n=%b want p=1 n=0", c, ifa.diff_po, ifa.diff_no);
            end
            tick();
        end
        vec++; if (acks_a != 1) begin errs++; $display("FAIL single_ackcnt got %0d want 1", acks_a); end
    endtask

    task automatic test_back_to_back();
        logic exp_p, exp_ack;
        reset_a();
        repeat (5) tick();
        ifa.req_i = 1'b1;
        repeat (3) tick();
        ifa.req_i = 1'b0;
        for (int c = 8; c <= 22; c++) begin
            exp_p   = (c >= 14) ? 1'b1 : (c >= 10) ? 1'b0 : 1'b1;
            exp_ack = (c == 10 || c == 14);
            vec++;
            if (ifa.diff_po !== exp_p || ifa.diff_no !== ~exp_p) begin
                errs++; $display("FAIL b2b_pair c%0d got p=%b n=%b want p=%b", c, ifa.diff_po, ifa.diff_no, exp_p);
            end
            vec++;
            if (ifa.ack_o !== exp_ack) begin
                errs++; $display("FAIL b2b_ack c%0d got %b want %b", c, ifa.ack_o, exp_ack);
            end
            if (c >= 18) begin
                vec++;
                if (ifa.busy_o !== 1'b0) begin errs++; $display("FAIL b2b_busy c%0d got %b want 0", c, ifa.busy_o); end
            end
            tick();
        end
        vec++; if (acks_a != 3) begin errs++; $display("FAIL b2b_ackcnt got %0d want 3", acks_a); end
    endtask

    task automatic test_saturate();
        reset_a();
        repeat (5) tick();
        ifa.req_i = 1'b1;
        repeat (8) tick();
        ifa.req_i = 1'b0;
        repeat (20) tick();
        vec++; if (acks_a != 5) begin errs++; $display("FAIL sat_acks got %0d want 5", acks_a); end
        vec++; if (ovfs_a != 3) begin errs++; $display("FAIL sat_ovfs got %0d want 3", ovfs_a); end
        vec++; if (ifa.busy_o !== 1'b0) begin errs++; $display("FAIL sat_busy got %b want 0", ifa.busy_o); end
        vec++;
        if (ifa.diff_po !== 1'b1 || ifa.diff_no !== 1'b0) begin
            errs++; $display("FAIL sat_pair got p=%b n=%b want p=1 n=0", ifa.diff_po, ifa.diff_no);
        end
    endtask

    task automatic test_sigint();
        reset_a();
        repeat (5) tick();
        ifa.req_i = 1'b1;
        tick();
        ifa.req_i = 1'b0;
        repeat (4) tick();
        ifa.sigint_test_i = 1'b1;
        tick();
        ifa.sigint_test_i = 1'b0;
        for (int c = 11; c <= 13; c++) begin
            vec++;
            if (ifa.diff_po !== 1'b1 || ifa.diff_no !== 1'b1) begin
                errs++; $display("FAIL sig_equal c%0d got p=%b n=%b want p=1 n=1", c, ifa.diff_po, ifa.diff_no);
            end
            ifa.req_i = (c == 12);
            tick();
        end
        ifa.req_i = 1'b0;
        vec++;
        if (ifa.diff_po !== 1'b1 || ifa.diff_no !== 1'b0) begin
            errs++; $display("FAIL sig_restore c14 got p=%b n=%b want p=1 n=0", ifa.diff_po, ifa.diff_no);
        end
        tick();
        vec++;
        if (ifa.diff_po !== 1'b0 || ifa.diff_no !== 1'b1 || ifa.ack_o !== 1'b1) begin
            errs++; $display("FAIL sig_toggle c15 got p=%b n=%b ack=%b want p=0 n=1 ack=1", ifa.diff_po, ifa.diff_no, ifa.ack_o);
        end
        tick();
        ifa.sigint_test_i = 1'b1;
        tick();
        ifa.sigint_test_i = 1'b0;
        for (int c = 17; c <= 20; c++) begin
            vec++;
            if (ifa.diff_po !== 1'b0 || ifa.diff_no !== 1'b1) begin
                errs++; $display("FAIL sig_ignored c%0d got p=%b n=%b want p=0 n=1", c, ifa.diff_po, ifa.diff_no);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        reset_a();
        repeat (5) tick();
        ifa.req_i = 1'b1;
        repeat (3) tick();
        ifa.req_i = 1'b0;
        vec++; if (ifa.busy_o !== 1'b1) begin errs++; $display("FAIL mid_busy_before got %b want 1", ifa.busy_o); end
        #2;
        rst_a = 1'b0;
        #1;
        vec++;
        if (ifa.diff_po !== 1'b0 || ifa.diff_no !== 1'b1 || ifa.busy_o !== 1'b0) begin
            errs++; $display("FAIL mid_reset got p=%b n=%b busy=%b want p=0 n=1 busy=0", ifa.diff_po, ifa.diff_no, ifa.busy_o);
        end
        @(posedge clk_i);
        #1;
        rst_a = 1'b1;
        acks_a = 0;
        repeat (15) tick();
        vec++; if (acks_a != 0) begin errs++; $display("FAIL mid_noack got %0d want 0", acks_a); end
        vec++;
        if (ifa.diff_po !== 1'b0 || ifa.diff_no !== 1'b1) begin
            errs++; $display("FAIL mid_pair got p=%b n=%b want p=0 n=1", ifa.diff_po, ifa.diff_no);
        end
    endtask

    task automatic test_hold1();
        logic exp_p;
        ifb.req_i = 1'b0;
        ifb.sigint_test_i = 1'b0;
        rst_b = 1'b0;
        @(posedge clk_i);
        #1;
        rst_b = 1'b1;
        acks_b = 0;
        ovfs_b = 0;
        repeat (5) tick();
        ifb.req_i = 1'b1;
        for (int c = 6; c <= 9; c++) begin
            tick();
            if (c == 9) ifb.req_i = 1'b0;
            exp_p = (c % 2 == 0);
            vec++;
            if (ifb.diff_po !== exp_p || ifb.diff_no !== ~exp_p || ifb.ack_o !== 1'b1) begin
                errs++; $display("FAIL h1_seq c%0d got p=%b n=%b ack=%b want p=%b ack=1", c, ifb.diff_po, ifb.diff_no, ifb.ack_o, exp_p);
            end
        end
        ifb.req_i = 1'b0;
        repeat (4) tick();
        vec++; if (acks_b != 4) begin errs++; $display("FAIL h1_acks got %0d want 4", acks_b); end
        vec++; if (ovfs_b != 0) begin errs++; $display("FAIL h1_ovf got %0d want 0", ovfs_b); end
        vec++;
        if (ifb.diff_po !== 1'b0 || ifb.busy_o !== 1'b0) begin
            errs++; $display("FAIL h1_end got p=%b busy=%b want p=0 busy=0", ifb.diff_po, ifb.busy_o);
        end
    endtask

    initial begin
        ifb.req_i = 1'b0;
        ifb.sigint_test_i = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_saturate();
        test_sigint();
        test_reset_mid();
        test_hold1();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/prim_diff_encode.md
PRIM_DIFF_ENCODE -- requirements
Module: prim_diff_encode

Interface
REQ-001 SHALL have parameter HoldCycles, default 4: minimum cycles each level is held on the pair; legal range 1..255.
REQ-002 SHALL have parameter TestCycles, default 3: cycles a forced signal-integrity fault is driven; legal range 1..255.
REQ-003 SHALL have parameter PendW, default 2: width of the pending-toggle counter.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk_i  input  1  clock; all state on rising edge.
REQ-006 rst_ni  input  1  asynchronous active-low reset.
REQ-007 req_i  input  1  single-cycle pulse requesting one level toggle (one event).
REQ-008 sigint_test_i  input  1  pulse requesting an injected integrity fault.
REQ-009 diff_po  output  1  positive wire of the differential pair, registered.
REQ-010 diff_no  output  1  negative wire of the differential pair, registered.
REQ-011 ack_o  output  1  registered pulse, high in the cycle a toggle first appears on the pair.
REQ-012 busy_o  output  1  high when state is not Idle or pending count is nonzero.
REQ-013 ovf_o  output  1  registered pulse: a request was dropped because the pending counter was saturated.

Function
REQ-014 SHALL hold internal level_q; diff_po = level_q; diff_no = ~level_q except in Test, where diff_no = level_q.
REQ-015 SHALL implement FSM states Idle, Hold, Test.
REQ-016 Pending counter pend_q (PendW bits): next = pend_q + req_i - taken; saturates at 2^PendW-1; req_i arriving with pend_q saturated and no take in that cycle SHALL be dropped and SHALL assert ovf_o next cycle.
REQ-017 Idle, sigint_test_i=1: go to Test, load counter TestCycles-1; Test has priority over pending/req_i; pending count SHALL be preserved and any same-cycle req_i counted.
REQ-018 Idle, no test, (pend_q>0 or req_i=1): take one request, toggle level_q, assert ack_o next cycle; if HoldCycles>1 go to Hold with counter HoldCycles-2, else stay Idle.
REQ-019 A req_i arriving in Idle with pend_q=0 SHALL be taken in that cycle without passing through pend_q (toggle visible next cycle).
REQ-020 Hold: decrement counter; at 0 return to Idle; new level stays on pair for exactly HoldCycles cycles before the next toggle can appear.
REQ-021 Test: drive equal wires; decrement counter; at 0 return to Idle with complementary wires restored next cycle; level_q unchanged by Test.
REQ-022 sigint_test_i outside Idle SHALL be ignored (not queued).
REQ-023 Consecutive toggles SHALL be spaced exactly HoldCycles cycles apart while pending is nonzero.
REQ-024 Every diff_po edge SHALL coincide with diff_no opposite edge in the same cycle (no encoder-side skew).
REQ-025 ack_o count SHALL equal number of accepted (non-dropped) requests once busy_o falls.

Reset
REQ-026 On rst_ni low, asynchronously: level_q=0, diff_po=0, diff_no=1, state=Idle, pend_q=0, counters=0, ack_o=0, ovf_o=0, busy_o=0.
REQ-027 Reset asserted mid-Hold or mid-Test SHALL discard pending requests and the fault; pair SHALL read 0/1 immediately.
REQ-028 First toggle after reset release SHALL drive diff_po=1, diff_no=0.

Verification
REQ-029 Defaults; reset release, req_i pulse at cycle 5 -> cycle 6 diff_po=1, diff_no=0, ack_o=1; pair stable through cycle 9.
REQ-030 Defaults; three req_i pulses on cycles 5,6,7 -> toggles at cycles 6,10,14 (p=1,0,1), three ack_o pulses, busy_o low from cycle 18.
REQ-031 PendW=2; req_i held high 8 cycles from Idle -> first taken immediately, pend_q saturates at 3, ovf_o pulses for dropped requests, total acks = accepted count (5).
REQ-032 Defaults, level 1 on pair, sigint_test_i in Idle -> diff_po=diff_no=1 for 3 cycles, then p=1/n=0; req_i during Test toggles pair right after Test ends.
REQ-033 Assert rst_ni low during Hold with pend_q=2 -> immediately p=0, n=1, busy_o=0; no ack_o after release without new req_i.
REQ-034 HoldCycles=1; req_i high 4 cycles -> toggle every cycle, p sequence 1,0,1,0, four acks, no ovf_o.
